// File: rtl/sync_fifo_comp_if.sv
// Handshake and status bundle for sync_fifo_comp.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_comp_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output rd_valid,
        output full,
        output empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/sync_fifo_comp.sv
// Single-clock FIFO with a registered read port, occupancy counter and
// one-cycle overflow/underflow pulses for rejected requests.
// A write into a full FIFO is still accepted when a read happens in the same
// cycle, because the read frees the slot the write is about to take.
module sync_fifo_comp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_comp_if.slave  io_fifo
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wrAccept;
    logic              w_rdAccept;
    logic              w_wrReject;
    logic              w_rdReject;
    logic [CW-1:0]     w_countNext;

    // Status flags come only from the registered count, so wr_en/rd_en never
    // reach full/empty combinationally.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Accept/reject decisions for this cycle's requests.
    always_comb begin
        w_wrAccept = 1'b0;
        w_rdAccept = 1'b0;
        w_wrReject = 1'b0;
        w_rdReject = 1'b0;
        if (io_fifo.rd_en) begin
            if (w_empty) begin
                w_rdReject = 1'b1;
            end else begin
                w_rdAccept = 1'b1;
            end
        end
        if (io_fifo.wr_en) begin
            if (!w_full || w_rdAccept) begin
                w_wrAccept = 1'b1;
            end else begin
                w_wrReject = 1'b1;
            end
        end
    end

    // Occupancy only moves when exactly one side is accepted.
    always_comb begin
        w_countNext = r_count;
        case ({w_wrAccept, w_rdAccept})
            2'b10:   w_countNext = r_count + CW'(1);
            2'b01:   w_countNext = r_count - CW'(1);
            default: w_countNext = r_count;
        endcase
    end

    // Storage array; left unreset since the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= io_fifo.wr_data;
        end
    end

    // Pointers and count; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= w_countNext;
        end
    end

    // Registered read port; rd_data holds its last word when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdData <= r_mem[r_rdPtr];
            end
        end
    end

    // Rejection pulses, visible for the single cycle after the offending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_wrReject;
            r_underflow <= w_rdReject;
        end
    end

    assign io_fifo.rd_data   = r_rdData;
    assign io_fifo.rd_valid  = r_rdValid;
    assign io_fifo.full      = w_full;
    assign io_fifo.empty     = w_empty;
    assign io_fifo.count     = r_count;
    assign io_fifo.overflow  = r_overflow;
    assign io_fifo.underflow = r_underflow;
endmodule

// File: tb/tb_sync_fifo_comp.sv
// Directed bench for sync_fifo_comp followed by a long random run against a queue model.
module tb_sync_fifo_comp;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;

    sync_fifo_comp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_comp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_fifo (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, then sample just after the edge.
    task automatic applyStimulus(input logic we, input logic [DATA_W-1:0] wd, input logic re);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic checkStatus(input string tag, input int cnt, input logic fl, input logic em);
        checkOutput({tag, " count"}, 32'(bus.count), 32'(cnt));
        checkOutput({tag, " full"},  32'(bus.full),  32'(fl));
        checkOutput({tag, " empty"}, 32'(bus.empty), 32'(em));
    endtask

    task automatic checkRead(input string tag, input logic [DATA_W-1:0] data, input logic valid);
        checkOutput({tag, " rd_data"},  32'(bus.rd_data),  32'(data));
        checkOutput({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(valid));
    endtask

    task automatic checkResetState(input string tag);
        checkStatus(tag, 0, 1'b0, 1'b1);
        checkRead(tag, 8'h00, 1'b0);
        checkOutput({tag, " overflow"},  32'(bus.overflow),  32'd0);
        checkOutput({tag, " underflow"}, 32'(bus.underflow), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] modelQ [$];
        logic [DATA_W-1:0] expData;
        logic              we;
        logic              re;
        logic              wrAcc;
        logic              rdAcc;
        logic              expOvf;
        logic              expUnf;
        logic [DATA_W-1:0] wd;
        int                wrPct;
        int                rdPct;

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        rst         = 1'b0;
        #1 rst = 1'b1;
        #2;
        $display("[TB] reset asserted before first clock edge");
        checkResetState("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetState("reset_held");
        rst = 1'b0;

        // Basic three-word write then read.
        $display("[TB] basic write/read");
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkStatus("w11", 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkStatus("w22", 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkStatus("w33", 3, 1'b0, 1'b0);
        checkRead("w33_noread", 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkRead("r11", 8'h11, 1'b1);
        checkStatus("r11", 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkRead("r22", 8'h22, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkRead("r33", 8'h33, 1'b1);
        checkStatus("r33", 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkRead("idle_hold", 8'h33, 1'b0);

        // Fill to full, then a rejected write.
        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
            checkStatus("fillA", i + 1, (i == DEPTH - 1), 1'b0);
        end
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("ovf_pulse", 32'(bus.overflow), 32'd1);
        checkStatus("ovf", DEPTH, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ovf_clear", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkRead("drainA", 8'hA0 + 8'(i), 1'b1);
            checkStatus("drainA", DEPTH - 1 - i, 1'b0, (i == DEPTH - 1));
        end

        // Simultaneous read and write while full, across the pointer wrap.
        $display("[TB] full pass-through");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
        end
        checkStatus("fillB", DEPTH, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b1);
            checkRead("pass", (i < DEPTH) ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - DEPTH), 1'b1);
            checkStatus("pass", DEPTH, 1'b1, 1'b0);
            checkOutput("pass overflow", 32'(bus.overflow), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkRead("drainC", 8'hC4 + 8'(i), 1'b1);
        end
        checkStatus("drainC", 0, 1'b0, 1'b1);

        // Underflow from empty, then write+read together while empty.
        $display("[TB] underflow cases");
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("unf_pulse", 32'(bus.underflow), 32'd1);
        checkRead("unf", 8'hCB, 1'b0);
        checkStatus("unf", 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkOutput("wr_rd_empty unf", 32'(bus.underflow), 32'd1);
        checkRead("wr_rd_empty", 8'hCB, 1'b0);
        checkStatus("wr_rd_empty", 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkRead("r5A", 8'h5A, 1'b1);
        checkOutput("r5A unf", 32'(bus.underflow), 32'd0);
        checkStatus("r5A", 0, 1'b0, 1'b1);

        // Asynchronous reset mid-operation.
        $display("[TB] mid-operation reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h01 + 8'(i), 1'b0);
        end
        checkStatus("pre_rst", 5, 1'b0, 1'b0);
        bus.wr_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        checkResetState("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("mid_rst_held");
        applyStimulus(1'b1, 8'h77, 1'b0);
        checkStatus("post_rst_w77", 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkRead("post_rst_r77", 8'h77, 1'b1);
        checkStatus("post_rst_r77", 0, 1'b0, 1'b1);

        // Random traffic against a queue model, with phases biased toward fill and drain.
        $display("[TB] random traffic");
        expData = 8'h77;
        for (int i = 0; i < 10000; i++) begin
            case ((i / 1250) % 4)
                0:       begin wrPct = 80; rdPct = 30; end
                1:       begin wrPct = 50; rdPct = 50; end
                2:       begin wrPct = 25; rdPct = 80; end
                default: begin wrPct = 90; rdPct = 90; end
            endcase
            we = ($urandom_range(99) < wrPct);
            re = ($urandom_range(99) < rdPct);
            wd = 8'($urandom);
            rdAcc  = re && (modelQ.size() != 0);
            wrAcc  = we && ((modelQ.size() < DEPTH) || rdAcc);
            expOvf = we && !wrAcc;
            expUnf = re && (modelQ.size() == 0);
            if (rdAcc) begin
                expData = modelQ.pop_front();
            end
            if (wrAcc) begin
                modelQ.push_back(wd);
            end
            applyStimulus(we, wd, re);
            checkRead("rand", expData, rdAcc);
            checkStatus("rand", modelQ.size(), (modelQ.size() == DEPTH), (modelQ.size() == 0));
            checkOutput("rand overflow",  32'(bus.overflow),  32'(expOvf));
            checkOutput("rand underflow", 32'(bus.underflow), 32'(expUnf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
